// File: rtl/maze_player_ctrl.sv
// Player-token controller: debounces four buttons, validates moves against the carved wall map,
// tracks position and move count, and flags arrival at the exit cell.
module maze_player_ctrl #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter int unsigned MOVE_CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  maze_valid,
   input  logic [4095:0]         maze_data,
   input  logic [2:0]            x_dimension,
   input  logic [2:0]            y_dimension,
   input  logic                  new_game,
   input  logic                  btn_up,
   input  logic                  btn_down,
   input  logic                  btn_left,
   input  logic                  btn_right,
   output logic [5:0]            player_x,
   output logic [5:0]            player_y,
   output logic [MOVE_CNT_W-1:0] move_count,
   output logic                  bump,
   output logic                  won
);

   localparam int unsigned NUM_BTN = 4;
   localparam int unsigned DB_W    = 16;
   localparam int unsigned POS_W   = 6;
   localparam int unsigned TGT_W   = 7;

   typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CHECK, S_MOVE, S_WON} state_t;

   state_t                      r_state, w_state_nxt;
   logic [NUM_BTN-1:0][DB_W-1:0] r_db_cnt;
   logic [NUM_BTN-1:0]          r_held;
   logic [NUM_BTN-1:0]          w_btn;
   logic [NUM_BTN-1:0]          w_acc;
   logic [POS_W-1:0]            r_px, r_py, r_tx, r_ty;
   logic [POS_W-1:0]            w_px_nxt, w_py_nxt, w_tx_nxt, w_ty_nxt;
   logic [MOVE_CNT_W-1:0]       r_cnt, w_cnt_nxt;
   logic                        r_bump, r_won, r_oob, r_wall;
   logic                        w_bump_nxt, w_won_nxt, w_oob_nxt, w_wall_nxt;
   logic [TGT_W-1:0]            w_dx, w_dy, w_tx, w_ty, w_w, w_h;
   logic [POS_W-1:0]            w_ex_x, w_ex_y;
   logic                        w_oob;

   // Bit 0 is the highest-priority direction (up).
   assign w_btn = {btn_right, btn_left, btn_down, btn_up};

   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         w_acc[i] = w_btn[i] && !r_held[i] && (r_db_cnt[i] == DEBOUNCE_CYCLES - 16'd1);
      end
   end

   // Debounce counters saturate so a long hold can never re-trigger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_db_cnt <= '0;
         r_held   <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (w_btn[i]) begin
               if (r_db_cnt[i] != '1) r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
               if (w_acc[i]) r_held[i] <= 1'b1;
            end else begin
               r_db_cnt[i] <= '0;
               r_held[i]   <= 1'b0;
            end
         end
      end
   end

   // Target cell in 7 bits; bit 6 set means underflow below 0 (or 64, also off-grid).
   always_comb begin
      w_dx = '0;
      w_dy = '0;
      if (w_acc[0])      w_dy = 7'h7F;
      else if (w_acc[1]) w_dy = 7'h01;
      else if (w_acc[2]) w_dx = 7'h7F;
      else if (w_acc[3]) w_dx = 7'h01;
      w_tx   = TGT_W'({1'b0, r_px}) + w_dx;
      w_ty   = TGT_W'({1'b0, r_py}) + w_dy;
      w_w    = TGT_W'({x_dimension, 3'b000}) + 7'd8;
      w_h    = TGT_W'({y_dimension, 3'b000}) + 7'd8;
      w_ex_x = POS_W'(w_w - 7'd2);
      w_ex_y = POS_W'(w_h - 7'd2);
      w_oob  = w_tx[6] | w_ty[6] | (w_tx >= w_w) | (w_ty >= w_h);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_px_nxt    = r_px;
      w_py_nxt    = r_py;
      w_cnt_nxt   = r_cnt;
      w_bump_nxt  = 1'b0;
      w_won_nxt   = r_won;
      w_tx_nxt    = r_tx;
      w_ty_nxt    = r_ty;
      w_oob_nxt   = r_oob;
      w_wall_nxt  = r_wall;
      if (r_state == S_IDLE) begin
         if (maze_valid) begin
            w_state_nxt = S_PLAY;
            w_px_nxt    = 6'd1;
            w_py_nxt    = 6'd1;
            w_cnt_nxt   = '0;
            w_won_nxt   = 1'b0;
         end
      end else if (new_game) begin
         w_state_nxt = maze_valid ? S_PLAY : S_IDLE;
         w_px_nxt    = 6'd1;
         w_py_nxt    = 6'd1;
         w_cnt_nxt   = '0;
         w_won_nxt   = 1'b0;
      end else if (!maze_valid) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_PLAY: begin
               if (|w_acc) begin
                  w_tx_nxt    = w_tx[POS_W-1:0];
                  w_ty_nxt    = w_ty[POS_W-1:0];
                  w_oob_nxt   = w_oob;
                  w_state_nxt = S_CHECK;
               end
            end
            S_CHECK: begin
               w_wall_nxt  = maze_data[{r_ty, r_tx}];
               w_state_nxt = S_MOVE;
            end
            S_MOVE: begin
               if (r_oob || r_wall) begin
                  w_bump_nxt  = 1'b1;
                  w_state_nxt = S_PLAY;
               end else begin
                  w_px_nxt  = r_tx;
                  w_py_nxt  = r_ty;
                  w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + MOVE_CNT_W'(1);
                  if (r_tx == w_ex_x && r_ty == w_ex_y) begin
                     w_won_nxt   = 1'b1;
                     w_state_nxt = S_WON;
                  end else begin
                     w_state_nxt = S_PLAY;
                  end
               end
            end
            S_WON:   w_state_nxt = S_WON;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_px   <= 6'd1;
         r_py   <= 6'd1;
         r_cnt  <= '0;
         r_bump <= 1'b0;
         r_won  <= 1'b0;
         r_tx   <= '0;
         r_ty   <= '0;
         r_oob  <= 1'b0;
         r_wall <= 1'b0;
      end else begin
         r_px   <= w_px_nxt;
         r_py   <= w_py_nxt;
         r_cnt  <= w_cnt_nxt;
         r_bump <= w_bump_nxt;
         r_won  <= w_won_nxt;
         r_tx   <= w_tx_nxt;
         r_ty   <= w_ty_nxt;
         r_oob  <= w_oob_nxt;
         r_wall <= w_wall_nxt;
      end
   end

   assign player_x   = r_px;
   assign player_y   = r_py;
   assign move_count = r_cnt;
   assign bump       = r_bump;
   assign won        = r_won;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Bench for maze_player_ctrl: directed scenarios plus randomized play, checked every cycle
// against an event-level model of the game rules.
module tb_maze_player_ctrl;

   localparam logic [15:0] DEB = 16'd4;

   logic          clk, rst_n, maze_valid, new_game;
   logic          btn_up, btn_down, btn_left, btn_right;
   logic [4095:0] maze_data;
   logic [2:0]    x_dimension, y_dimension;
   logic [5:0]    player_x, player_y;
   logic [15:0]   move_count;
   logic          bump, won;

   maze_player_ctrl #(.DEBOUNCE_CYCLES(DEB), .MOVE_CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .maze_valid(maze_valid), .maze_data(maze_data),
      .x_dimension(x_dimension), .y_dimension(y_dimension), .new_game(new_game),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .player_x(player_x), .player_y(player_y), .move_count(move_count),
      .bump(bump), .won(won)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int bump_seen = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Game model: a resolved move lands two edges after the accepting edge.
   int m_db[4];
   bit m_active, m_won, m_bump;
   int m_x, m_y, m_mc, m_busy, m_tx, m_ty;

   task automatic model_step();
      bit acc[4];
      bit b[4];
      int old, w, h;
      bit blocked;
      b[0] = btn_up; b[1] = btn_down; b[2] = btn_left; b[3] = btn_right;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) begin
            old = m_db[i];
            if (m_db[i] < 65535) m_db[i]++;
            acc[i] = (m_db[i] == int'(DEB)) && (old != int'(DEB));
         end else begin
            m_db[i] = 0;
            acc[i]  = 1'b0;
         end
      end
      w = 8 * (int'(x_dimension) + 1);
      h = 8 * (int'(y_dimension) + 1);
      m_bump = 1'b0;
      if (!m_active) begin
         if (maze_valid) begin
            m_active = 1'b1; m_x = 1; m_y = 1; m_mc = 0; m_won = 1'b0; m_busy = 0;
         end
      end else if (new_game) begin
         m_x = 1; m_y = 1; m_mc = 0; m_won = 1'b0; m_busy = 0;
         m_active = maze_valid;
      end else if (!maze_valid) begin
         m_active = 1'b0; m_busy = 0;
      end else if (m_won) begin
         m_busy = 0;
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            if (m_tx < 0 || m_ty < 0 || m_tx >= w || m_ty >= h) blocked = 1'b1;
            else blocked = maze_data[m_ty * 64 + m_tx];
            if (blocked) m_bump = 1'b1;
            else begin
               m_x = m_tx; m_y = m_ty;
               if (m_mc < 65535) m_mc++;
               if (m_x == w - 2 && m_y == h - 2) m_won = 1'b1;
            end
         end
      end else if (acc[0] || acc[1] || acc[2] || acc[3]) begin
         m_tx = m_x; m_ty = m_y;
         if (acc[0])      m_ty = m_y - 1;
         else if (acc[1]) m_ty = m_y + 1;
         else if (acc[2]) m_tx = m_x - 1;
         else             m_tx = m_x + 1;
         m_busy = 2;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) m_db[i] = 0;
         m_active = 1'b0; m_won = 1'b0; m_bump = 1'b0;
         m_x = 1; m_y = 1; m_mc = 0; m_busy = 0; m_tx = 0; m_ty = 0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("player_x", int'(player_x), m_x);
         check("player_y", int'(player_y), m_y);
         check("move_count", int'(move_count), m_mc);
         check("bump", int'(bump), int'(m_bump));
         check("won", int'(won), int'(m_won));
         check("bump_won_excl", int'(bump && won), 0);
         if (bump) bump_seen++;
      end
   end

   task automatic press(input int dir);
      case (dir)
         0: btn_up = 1'b1;
         1: btn_down = 1'b1;
         2: btn_left = 1'b1;
         default: btn_right = 1'b1;
      endcase
      repeat (int'(DEB)) @(negedge clk);
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic restart_open();
      maze_valid = 1'b0;
      repeat (2) @(negedge clk);
      maze_data = '0;
      maze_valid = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   int b0, low_cnt;

   initial begin
      rst_n = 1'b0; maze_valid = 1'b0; new_game = 1'b0; maze_data = '0;
      x_dimension = 3'd0; y_dimension = 3'd0;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_x", int'(player_x), 1);
      check("rst_y", int'(player_y), 1);
      check("rst_cnt", int'(move_count), 0);
      check("rst_bump", int'(bump), 0);
      check("rst_won", int'(won), 0);
      rst_n = 1'b1;
      maze_valid = 1'b1;
      @(negedge clk);

      // Debounced right press: accepted on 4th high edge, visible after edge 6
      btn_right = 1'b1;
      repeat (4) @(negedge clk);
      check("t2_x_edge4", int'(player_x), 1);
      @(negedge clk);
      check("t2_x_edge5", int'(player_x), 1);
      @(negedge clk);
      check("t2_x_edge6", int'(player_x), 2);
      check("t2_cnt", int'(move_count), 1);
      repeat (100) @(negedge clk);
      check("t2_hold_x", int'(player_x), 2);
      check("t2_hold_cnt", int'(move_count), 1);
      btn_right = 1'b0;
      repeat (3) @(negedge clk);

      // Async reset while a move is in flight
      btn_right = 1'b1;
      repeat (4) @(negedge clk);
      btn_right = 1'b0;
      @(negedge clk);
      check("t1_pre_x", int'(player_x), 2);
      #2 rst_n = 1'b0;
      #1;
      check("t1_x", int'(player_x), 1);
      check("t1_y", int'(player_y), 1);
      check("t1_cnt", int'(move_count), 0);
      check("t1_bump", int'(bump), 0);
      check("t1_won", int'(won), 0);
      maze_data[66] = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Wall east of start
      b0 = bump_seen;
      press(3);
      check("t3_bumps", bump_seen - b0, 1);
      check("t3_x", int'(player_x), 1);
      check("t3_y", int'(player_y), 1);
      check("t3_cnt", int'(move_count), 0);

      // Off-grid on the left edge
      restart_open();
      press(2);
      check("t4_x0", int'(player_x), 0);
      b0 = bump_seen;
      press(2);
      check("t4_bumps", bump_seen - b0, 1);
      check("t4_x_stay", int'(player_x), 0);
      check("t4_cnt", int'(move_count), 1);

      // Up beats right
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      @(negedge clk);
      press(1);
      check("t5_y2", int'(player_y), 2);
      btn_up = 1'b1; btn_right = 1'b1;
      repeat (int'(DEB)) @(negedge clk);
      btn_up = 1'b0; btn_right = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_x", int'(player_x), 1);
      check("t5_y", int'(player_y), 1);
      check("t5_cnt", int'(move_count), 2);

      // Walk to the exit of an 8x8 map
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 5; k++) press(3);
      for (int k = 0; k < 5; k++) press(1);
      check("t6_won", int'(won), 1);
      check("t6_x", int'(player_x), 6);
      check("t6_y", int'(player_y), 6);
      check("t6_cnt", int'(move_count), 10);
      press(2);
      check("t6_hold_x", int'(player_x), 6);
      check("t6_hold_won", int'(won), 1);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      check("t6_ng_x", int'(player_x), 1);
      check("t6_ng_won", int'(won), 0);
      check("t6_ng_cnt", int'(move_count), 0);
      press(3);
      maze_valid = 1'b0;
      repeat (2) @(negedge clk);
      press(3);
      check("t6_idle_x", int'(player_x), 2);
      check("t6_idle_cnt", int'(move_count), 1);

      // Randomized play
      maze_valid = 1'b1;
      low_cnt = 0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 4) == 0) btn_up = ~btn_up;
         if ($urandom_range(0, 4) == 0) btn_down = ~btn_down;
         if ($urandom_range(0, 4) == 0) btn_left = ~btn_left;
         if ($urandom_range(0, 4) == 0) btn_right = ~btn_right;
         new_game = ($urandom_range(0, 199) == 0);
         if (maze_valid) begin
            if ($urandom_range(0, 299) == 0) begin
               maze_valid = 1'b0;
               low_cnt = 0;
            end
         end else begin
            low_cnt++;
            if (low_cnt == 2) begin
               if ($urandom_range(0, 2) == 0) begin
                  maze_data = '0;
                  x_dimension = 3'd0;
                  y_dimension = 3'd0;
               end else begin
                  for (int k = 0; k < 128; k++) maze_data[k*32 +: 32] = $urandom & $urandom;
                  x_dimension = 3'($urandom_range(0, 7));
                  y_dimension = 3'($urandom_range(0, 7));
               end
            end
            if (low_cnt >= 3 && $urandom_range(0, 3) == 0) maze_valid = 1'b1;
         end
      end
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
